// File: rtl/sel_mux_reg_if.sv
// Bus bundle for sel_mux_reg: capture-side handshake, select controls and registered output side.
interface sel_mux_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    sel_load;
    logic                    sel_lock;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [15:0]             err_cnt;

    modport master (
        output in_data, sel, in_valid, sel_load, sel_lock, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err, err_cnt
    );

    modport slave (
        input  in_data, sel, in_valid, sel_load, sel_lock, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err, err_cnt
    );
endinterface

// File: rtl/sel_mux_reg.sv
// Registered N-input selector with valid/ready output stage, lockable select
// register and out-of-range select detection with a saturating error count.
module sel_mux_reg #(
    parameter int WIDTH       = 32,
    parameter int NUM_IN      = 8,
    parameter int DEFAULT_IDX = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    sel_mux_reg_if.slave  bus
);
    localparam int               SEL_W   = $clog2(NUM_IN);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_IDX);

    if (NUM_IN < 2 || NUM_IN > 256 || DEFAULT_IDX < 0 || DEFAULT_IDX >= NUM_IN) begin : g_bad_params
        $error("sel_mux_reg: NUM_IN must be 2..256 and DEFAULT_IDX < NUM_IN");
    end

    logic [WIDTH-1:0] in_arr [NUM_IN];
    logic             in_range;
    logic [SEL_W-1:0] fixed_sel;
    logic [SEL_W-1:0] eff_sel;
    logic             err;
    logic             capture;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             sel_err_q,   sel_err_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] lock_q,      lock_d;
    logic [15:0]      err_cnt_q,   err_cnt_d;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            in_arr[k] = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // For power-of-two NUM_IN every select is in range, so err folds to 0.
    assign in_range  = ({{(32-SEL_W){1'b0}}, bus.sel} < 32'(NUM_IN));
    assign fixed_sel = in_range ? bus.sel : DEF_SEL;
    assign eff_sel   = bus.sel_lock ? lock_q : fixed_sel;
    assign err       = !bus.sel_lock && !in_range;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        sel_err_d   = sel_err_q;
        out_valid_d = out_valid_q;
        lock_d      = lock_q;
        err_cnt_d   = err_cnt_q;

        if (bus.sel_load) begin
            lock_d = fixed_sel;
        end

        if (capture) begin
            out_data_d  = in_arr[eff_sel];
            out_sel_d   = eff_sel;
            sel_err_d   = err;
            out_valid_d = 1'b1;
            if (err && err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_sel_q   <= DEF_SEL;
            sel_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            lock_q      <= DEF_SEL;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            out_valid_q <= out_valid_d;
            lock_q      <= lock_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_sel_mux_reg.sv
// Self-checking bench for sel_mux_reg (WIDTH=32, NUM_IN=7, DEFAULT_IDX=0).
module tb_sel_mux_reg;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 7;
    localparam int SEL_W  = $clog2(NUM_IN);

    logic clk;
    logic reset_n;
    logic [WIDTH-1:0] din [NUM_IN];

    sel_mux_reg_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    sel_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEFAULT_IDX(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.in_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            bus.in_data[k*WIDTH +: WIDTH] = din[k];
        end
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } exp_t;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic             rdy;
        logic             load;
        logic             lock;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [SEL_W-1:0] exp_sel;
        logic             exp_err;
        logic [15:0]      exp_cnt;
    } vec_t;

    exp_t             sb [$];
    int               n_cmp = 0;
    int               n_err = 0;

    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [SEL_W-1:0] m_sel;
    logic             m_err;
    logic [SEL_W-1:0] m_lock;
    logic [15:0]      m_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [SEL_W-1:0] fix(logic [SEL_W-1:0] s);
        return (s < SEL_W'(NUM_IN)) ? s : '0;
    endfunction

    function automatic vec_t mkv(int s, bit v, bit r, bit ld, bit lk, bit ev,
                                 logic [31:0] ed, int es, bit ee, int ec);
        vec_t t;
        t.sel = SEL_W'(s); t.valid = v; t.rdy = r; t.load = ld; t.lock = lk;
        t.exp_valid = ev; t.exp_data = ed; t.exp_sel = SEL_W'(es);
        t.exp_err = ee; t.exp_cnt = 16'(ec);
        return t;
    endfunction

    task automatic set_in(int s, bit v, bit r, bit ld, bit lk);
        bus.sel       = SEL_W'(s);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.sel_load  = ld;
        bus.sel_lock  = lk;
    endtask

    // One clock: predict before the edge, push expectation, check after the edge.
    task automatic cycle();
        logic [SEL_W-1:0] s_pre;
        logic             rdy_exp, err_e, cap, ld_pre, rdy_pre;
        logic [SEL_W-1:0] eff;
        exp_t             e;
        s_pre   = bus.sel;
        ld_pre  = bus.sel_load;
        rdy_pre = bus.out_ready;
        rdy_exp = !m_valid || rdy_pre;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
        err_e = !bus.sel_lock && (s_pre >= SEL_W'(NUM_IN));
        eff   = bus.sel_lock ? m_lock : fix(s_pre);
        cap   = reset_n && bus.in_valid && rdy_exp;
        if (cap) sb.push_back('{din[eff], eff, err_e});
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_valid = 0; m_data = '0; m_sel = '0; m_err = 0; m_lock = '0; m_cnt = '0;
            sb.delete();
        end else begin
            if (ld_pre) m_lock = fix(s_pre);
            if (cap) begin
                e = sb.pop_front();
                m_data = e.data; m_sel = e.sel; m_err = e.err; m_valid = 1;
                if (e.err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (m_valid && rdy_pre) begin
                m_valid = 0;
            end
        end
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data",  bus.out_data,       m_data);
        chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
        chk("sel_err",   32'(bus.sel_err),   32'(m_err));
        chk("err_cnt",   32'(bus.err_cnt),   32'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [$];

        for (int k = 0; k < NUM_IN; k++) din[k] = 32'hA000_0000 + 32'(k);
        for (int s = 0; s < 7; s++)
            vecs.push_back(mkv(s, 1, 1, 0, 0, 1, 32'hA000_0000 + 32'(s), s, 0, 0));
        vecs.push_back(mkv(7, 1, 1, 0, 0, 1, 32'hA000_0000, 0, 1, 1));
        vecs.push_back(mkv(2, 1, 1, 0, 0, 1, 32'hA000_0002, 2, 0, 1));
        vecs.push_back(mkv(5, 0, 1, 1, 0, 0, 32'hA000_0002, 2, 0, 1));
        for (int s = 0; s < 8; s++)
            vecs.push_back(mkv(s, 1, 1, 0, 1, 1, 32'hA000_0005, 5, 0, 1));
        vecs.push_back(mkv(2, 1, 1, 1, 1, 1, 32'hA000_0005, 5, 0, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 1, 1, 32'hA000_0002, 2, 0, 1));
        vecs.push_back(mkv(6, 1, 1, 0, 0, 1, 32'hA000_0006, 6, 0, 1));
        vecs.push_back(mkv(6, 0, 1, 0, 0, 0, 32'hA000_0006, 6, 0, 1));

        m_valid = 0; m_data = '0; m_sel = '0; m_err = 0; m_lock = '0; m_cnt = '0;
        reset_n = 1'b0;
        set_in(3, 1, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);

        // Reset held with a pending capture request
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_data",  bus.out_data,       32'd0);
            chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
            chk("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        end
        reset_n = 1'b1;
        cycle();
        chk("first_capture", bus.out_data, 32'hA000_0003);

        foreach (vecs[i]) begin
            set_in(vecs[i].sel, vecs[i].valid, vecs[i].rdy, vecs[i].load, vecs[i].lock);
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  bus.out_data,       vecs[i].exp_data);
            chk($sformatf("vec%0d_sel", i),   32'(bus.out_sel),   32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_err", i),   32'(bus.sel_err),   32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_cnt", i),   32'(bus.err_cnt),   32'(vecs[i].exp_cnt));
        end

        // Backpressure: hold through 5 stalled cycles while inputs move
        set_in(4, 1, 1, 0, 0);
        cycle();
        chk("bp_capture", bus.out_data, 32'hA000_0004);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NUM_IN; k++) din[k] = 32'hB000_0000 + 32'(k);
            set_in(i + 1, 1, 0, 0, 0);
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            cycle();
            chk("bp_hold_data",  bus.out_data,     32'hA000_0004);
            chk("bp_hold_sel",   32'(bus.out_sel), 32'd4);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        set_in(1, 1, 1, 0, 0);
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        chk("bp_drain_capture", bus.out_data, 32'hB000_0001);
        chk("bp_drain_valid",   32'(bus.out_valid), 32'd1);

        // Saturation of the error counter
        for (int k = 0; k < NUM_IN; k++) din[k] = 32'hA000_0000 + 32'(k);
        set_in(7, 1, 1, 0, 0);
        for (int i = 0; i < 65540; i++) cycle();
        chk("sat_cnt",  32'(bus.err_cnt), 32'h0000_FFFF);
        chk("sat_err",  32'(bus.sel_err), 32'd1);
        chk("sat_data", bus.out_data,     32'hA000_0000);
        cycle();
        chk("sat_hold", 32'(bus.err_cnt), 32'h0000_FFFF);
        reset_n = 1'b0;
        cycle();
        chk("sat_reset_cnt", 32'(bus.err_cnt), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("post_reset_cnt", 32'(bus.err_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sel_mux_reg.md
# sel_mux_reg

Parametrised N-input, registered datapath multiplexer with a valid/ready handshake, a lockable select register, and out-of-range select detection. It is the next generation of the fixed 7-input, 32-bit combinational selector in the datapath. It is used wherever an operand source must be chosen and staged for one cycle before the ALU, register file or memory interface. Width, input count and default input are set per instance.

## Interface
- WIDTH, 32: data width of each input and of the output.
- NUM_IN, 8: number of inputs; legal range is 2 to 256.
- DEFAULT_IDX, 0: input used for an out-of-range select; also the reset value of the select registers; must be < NUM_IN.
- SEL_W, derived as $clog2(NUM_IN): select width; not overridable.

- clk  in  1  single clock; rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k is in_data[k*WIDTH +: WIDTH].
- sel  in  SEL_W  raw select.
- in_valid  in  1  request to capture the selected input.
- in_ready  out  1  block can accept a capture this cycle.
- sel_load  in  1  capture sel into the lock register.
- sel_lock  in  1  use the lock register instead of sel.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  effective index that produced out_data.
- out_valid  out  1  out_data holds an unconsumed value.
- out_ready  in  1  consumer accepts out_data.
- sel_err  out  1  the current out_data came from an out-of-range select.
- err_cnt  out  16  saturating count of out-of-range captures.

## Operation
- **Range correction:** fixed(s) = s when s < NUM_IN, otherwise DEFAULT_IDX.
- **Effective select:** eff_sel = sel_lock ? lock_q : fixed(sel).
- **Lock register lock_q:**
  - When sel_load=1, lock_q <= fixed(sel) on the clock edge.
  - A capture in the same cycle uses the old lock_q.
- **Error flag:** err = (!sel_lock) && (sel >= NUM_IN). When NUM_IN is a power of two, err is constant 0.
- **Ready:** in_ready = !out_valid || out_ready. It is combinational and has no dependency on in_valid.
- **Capture** (in_valid && in_ready):
  - out_data <= input[eff_sel]
  - out_sel <= eff_sel
  - sel_err <= err
  - out_valid <= 1
  - err_cnt <= err_cnt + 1 when err, saturating at 16'hFFFF.
- **Drain:** when out_valid && out_ready && !(in_valid), out_valid <= 0. out_data, out_sel and sel_err keep their values.
- **Stall:** when out_valid && !out_ready:
  - out_data, out_sel, sel_err and out_valid are held.
  - Input changes are ignored.
- **Simultaneous drain and capture:** the new value replaces the old one in the same edge, with no bubble.
- **Reset (reset_n=0 at a clock edge):**
  - out_valid=0, out_data=0, out_sel=DEFAULT_IDX, sel_err=0, lock_q=DEFAULT_IDX, err_cnt=0.
  - Any pending output is discarded.
  - in_ready reads 1 on the cycle after reset.
  - Reset takes priority over capture and over sel_load.
- **Synthesis checks:** DEFAULT_IDX >= NUM_IN or NUM_IN < 2 is an elaboration error.

## Timing
- Latency is 1 cycle: a value captured at edge N is visible on out_data after edge N, with out_valid=1.
- With out_ready held at 1, throughput is one capture per cycle.
- The sel_load → sel_lock use path takes 1 cycle. A lock loaded at edge N applies to captures from edge N+1 onward.
- There are no combinational paths from in_data or sel to any output.
- in_ready depends combinationally on out_ready.
- The err_cnt update is visible one cycle after the offending capture.

## Test plan
- **Reset:**
  - Stimulus: hold reset_n=0 for 2 cycles with in_valid=1 and sel=3.
  - Response: out_valid=0, out_data=0, out_sel=0, err_cnt=0 and in_ready=1 throughout; the first capture happens on the first edge with reset_n=1.
- **Streaming (WIDTH=32, NUM_IN=7):**
  - Stimulus: input k = 32'hA000_000k; out_ready=1; sel steps 0..6 on consecutive cycles with in_valid=1.
  - Response: out_data = A000_0000..A000_0006 on 7 consecutive cycles, out_sel matching, sel_err=0.
- **Out-of-range:**
  - Stimulus: sel=7 with NUM_IN=7 and DEFAULT_IDX=0.
  - Response: out_data=A000_0000, out_sel=0, sel_err=1, err_cnt=1. A following capture with sel=2 clears sel_err and leaves err_cnt=1.
- **Backpressure:**
  - Stimulus: capture sel=4, then out_ready=0 for 5 cycles while sel and in_data change.
  - Response: in_ready=0 and out_data=A000_0004 held throughout. Raising out_ready with in_valid=1 drains and captures on the same edge.
- **Lock:**
  - Stimulus: sel=5 with sel_load=1 for one cycle, then sel_lock=1 with sel cycling 0..6.
  - Response: every capture yields A000_0005.
  - Stimulus: sel_load=1 with sel=2 in the same cycle as a capture.
  - Response: that capture yields A000_0005; the next yields A000_0002.
- **Saturation:**
  - Stimulus: 65 540 consecutive out-of-range captures.
  - Response: err_cnt is 16'hFFFF and stays there; a mid-run reset_n pulse returns err_cnt to 0.
